div_result_bcd: RTL



---
 rtl/div_fmt_pkg.sv | 16 +
 rtl/div_result_bcd_if.sv | 32 +++
 rtl/bcd_dd_step.sv | 34 +++
 rtl/div_result_bcd.sv | 133 +++++++++++++
 4 files changed

// File: rtl/div_fmt_pkg.sv
// Shared definitions for the divider result formatter.
// Holds the controller state encoding, the BCD digit width, the digit code shown
// for an error/blank result, and the double-dabble add-3 threshold.
package div_fmt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned BCD_DIGIT_W     = 4;
  localparam logic [3:0]  BCD_ERR_DIGIT   = 4'hF;
  localparam logic [3:0]  BCD_ADD3_THRESH = 4'd5;

endpackage

// File: rtl/div_result_bcd_if.sv
// Handshake bundle between the divider, the BCD formatter and the display logic.
// Upstream:   in_valid/in_ready with quotient, remainder, divisor.
// Downstream: out_valid/out_ready with q_bcd, r_bcd, div_by_zero.
// master: the side driving operands and accepting results (divider/display side).
// slave:  the formatter itself.
interface div_result_bcd_if
  import div_fmt_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NDIG  = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            quotient;
  logic [WIDTH-1:0]            remainder;
  logic [WIDTH-1:0]            divisor;
  logic                        out_valid;
  logic                        out_ready;
  logic [BCD_DIGIT_W*NDIG-1:0] q_bcd;
  logic [BCD_DIGIT_W*NDIG-1:0] r_bcd;
  logic                        div_by_zero;

  modport master (
    output in_valid, quotient, remainder, divisor, out_ready,
    input  in_ready, out_valid, q_bcd, r_bcd, div_by_zero
  );

  modport slave (
    input  in_valid, quotient, remainder, divisor, out_ready,
    output in_ready, out_valid, q_bcd, r_bcd, div_by_zero
  );
endinterface

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// concatenation {bcd, bin} left by one bit. Purely combinational.
// Ports:
//   bcd      BCD accumulator before this step
//   bin      binary shift register before this step
//   bcd_next BCD accumulator after correction and shift
//   bin_next binary shift register after shift (LSB filled with 0)
module bcd_dd_step
  import div_fmt_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NDIG  = 2
) (
  input  logic [BCD_DIGIT_W*NDIG-1:0] bcd,
  input  logic [WIDTH-1:0]            bin,
  output logic [BCD_DIGIT_W*NDIG-1:0] bcd_next,
  output logic [WIDTH-1:0]            bin_next
);

  logic [BCD_DIGIT_W*NDIG-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_ADD3_THRESH) begin
        adj[i*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
    end
  end

  // Top bit of adj is always 0 given the NDIG sizing, so dropping it loses nothing.
  assign {bcd_next, bin_next} = {adj, bin} << 1;

endmodule

// File: rtl/div_result_bcd.sv
// Divider result formatter. Accepts a quotient/remainder/divisor triple, flags a
// zero divisor, converts quotient and remainder to packed BCD with WIDTH
// double-dabble iterations, and holds the result until the consumer takes it.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   slave side of div_result_bcd_if (both handshakes and data)
module div_result_bcd
  import div_fmt_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NDIG  = 2
) (
  input logic               clk,
  input logic               rst_n,
  div_result_bcd_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = BCD_DIGIT_W * NDIG;

  // NDIG digits must be able to hold the largest WIDTH-bit value.
  if (10 ** NDIG <= 2 ** WIDTH - 1) begin : g_ndig_chk
    $error("NDIG too small for WIDTH");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  q_bin_q, q_bin_d, r_bin_q, r_bin_d;
  logic [BcdW-1:0]   q_acc_q, q_acc_d, r_acc_q, r_acc_d;
  logic              dz_q, dz_d;
  logic [BcdW-1:0]   q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  q_bin_step, r_bin_step;
  logic [BcdW-1:0]   q_acc_step, r_acc_step;

  bcd_dd_step #(.WIDTH(WIDTH), .NDIG(NDIG)) u_step_q (
    .bcd      (q_acc_q),
    .bin      (q_bin_q),
    .bcd_next (q_acc_step),
    .bin_next (q_bin_step)
  );

  bcd_dd_step #(.WIDTH(WIDTH), .NDIG(NDIG)) u_step_r (
    .bcd      (r_acc_q),
    .bin      (r_bin_q),
    .bcd_next (r_acc_step),
    .bin_next (r_bin_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_bin_d = q_bin_q;
    r_bin_d = r_bin_q;
    q_acc_d = q_acc_q;
    r_acc_d = r_acc_q;
    dz_d    = dz_q;
    q_bcd_d = q_bcd_q;
    r_bcd_d = r_bcd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          q_bin_d = bus.quotient;
          r_bin_d = bus.remainder;
          q_acc_d = '0;
          r_acc_d = '0;
          dz_d    = (bus.divisor == '0);
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        q_bin_d = q_bin_step;
        r_bin_d = r_bin_step;
        q_acc_d = q_acc_step;
        r_acc_d = r_acc_step;
        cnt_d   = cnt_q - 1'b1;
        // Last iteration: publish straight from the step outputs on this edge.
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          dbz_d   = dz_q;
          if (dz_q) begin
            q_bcd_d = {NDIG{BCD_ERR_DIGIT}};
            r_bcd_d = {NDIG{BCD_ERR_DIGIT}};
          end else begin
            q_bcd_d = q_acc_step;
            r_bcd_d = r_acc_step;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_bin_q <= '0;
      r_bin_q <= '0;
      q_acc_q <= '0;
      r_acc_q <= '0;
      dz_q    <= 1'b0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_bin_q <= q_bin_d;
      r_bin_q <= r_bin_d;
      q_acc_q <= q_acc_d;
      r_acc_q <= r_acc_d;
      dz_q    <= dz_d;
      q_bcd_q <= q_bcd_d;
      r_bcd_q <= r_bcd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.q_bcd       = q_bcd_q;
  assign bus.r_bcd       = r_bcd_q;
  assign bus.div_by_zero = dbz_q;

endmodule
